i2s_tx_feeder: RTL

- Upstream neighbour of the I2S transmitter, running in the system clock domain.
- Generates the SCLK and LRCK bit clocks and buffers stereo samples from the DSP pipeline in a small FIFO behind a valid/ready handshake.
- Presents parallel left/right words to the transmitter, and updates each word only while the transmitter is not loading it.

---
 rtl/i2s_tx_feeder.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/i2s_tx_feeder.sv
// I2S transmitter feeder: generates SCLK/LRCK from the system clock, buffers
// stereo sample pairs in a small FIFO, and updates the parallel left/right
// words at mid-slot points so the transmitter never sees a word change near
// the LRCK edge at which it loads that word.
module i2s_tx_feeder #(
    parameter int PDATA_WIDTH = 32,
    parameter int SCLK_DIV    = 4,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic                          clk_in,
    input  logic                          rst_in,
    input  logic                          en_in,
    input  logic                          s_valid_in,
    output logic                          s_ready_out,
    input  logic [PDATA_WIDTH-1:0]        s_ldata_in,
    input  logic [PDATA_WIDTH-1:0]        s_rdata_in,
    output logic                          sclk_out,
    output logic                          lrck_out,
    output logic [PDATA_WIDTH-1:0]        pldata_out,
    output logic [PDATA_WIDTH-1:0]        prdata_out,
    output logic [$clog2(FIFO_DEPTH):0]   level_out,
    output logic                          underrun_out
);

    localparam int DIV_W = (SCLK_DIV > 1) ? $clog2(SCLK_DIV) : 1;
    localparam int BIT_W = $clog2(2 * PDATA_WIDTH);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int LVL_W = PTR_W + 1;

    localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(SCLK_DIV - 1);
    localparam logic [BIT_W-1:0] BIT_LAST  = BIT_W'(2 * PDATA_WIDTH - 1);
    localparam logic [BIT_W-1:0] RIGHT_BIT = BIT_W'(PDATA_WIDTH / 2);
    localparam logic [BIT_W-1:0] SLOT_BIT  = BIT_W'(PDATA_WIDTH);
    localparam logic [BIT_W-1:0] POP_BIT   = BIT_W'(PDATA_WIDTH + PDATA_WIDTH / 2);
    localparam logic [LVL_W-1:0] LVL_FULL  = LVL_W'(FIFO_DEPTH);

    logic [DIV_W-1:0]         div_cnt;
    logic [BIT_W-1:0]         bit_cnt;
    logic [BIT_W-1:0]         bit_next;
    logic                     tick;
    logic                     fall;
    logic                     pop_evt;
    logic                     right_evt;

    logic [2*PDATA_WIDTH-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0]         wr_ptr;
    logic [PTR_W-1:0]         rd_ptr;
    logic [LVL_W-1:0]         level;
    logic                     fifo_empty;
    logic                     fifo_full;
    logic                     push;
    logic                     pop;
    logic [PDATA_WIDTH-1:0]   pending;

    // Event decode: divider wrap, SCLK falling edge, and the two mid-slot update points
    always_comb begin
        tick       = en_in && (div_cnt == DIV_LAST);
        fall       = tick && sclk_out;
        bit_next   = (bit_cnt == BIT_LAST) ? '0 : bit_cnt + BIT_W'(1);
        pop_evt    = fall && (bit_next == POP_BIT);
        right_evt  = fall && (bit_next == RIGHT_BIT);
        fifo_empty = (level == '0);
        fifo_full  = (level == LVL_FULL);
        push       = s_valid_in && !fifo_full;
        pop        = pop_evt && !fifo_empty;
    end

    assign s_ready_out = !fifo_full;
    assign level_out   = level;

    // Bit clock generation; disabling parks everything at the start of a frame
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            div_cnt  <= '0;
            bit_cnt  <= '0;
            sclk_out <= 1'b0;
            lrck_out <= 1'b0;
        end else if (!en_in) begin
            div_cnt  <= '0;
            bit_cnt  <= '0;
            sclk_out <= 1'b0;
            lrck_out <= 1'b0;
        end else if (tick) begin
            div_cnt  <= '0;
            sclk_out <= ~sclk_out;
            if (fall) begin
                bit_cnt  <= bit_next;
                lrck_out <= (bit_next >= SLOT_BIT);
            end
        end else begin
            div_cnt <= div_cnt + DIV_W'(1);
        end
    end

    // FIFO storage; contents are only meaningful between the pointers, so no reset
    always_ff @(posedge clk_in) begin
        if (push) begin
            mem[wr_ptr] <= {s_ldata_in, s_rdata_in};
        end
    end

    // FIFO pointers and occupancy; an underrun pop never consumes the same-cycle push
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   level <= level + LVL_W'(1);
                2'b01:   level <= level - LVL_W'(1);
                default: level <= level;
            endcase
        end
    end

    // Word updates: left and pending right at mid right slot, right at mid left slot
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            pldata_out   <= '0;
            prdata_out   <= '0;
            pending      <= '0;
            underrun_out <= 1'b0;
        end else begin
            underrun_out <= pop_evt && fifo_empty;
            if (pop_evt) begin
                if (fifo_empty) begin
                    pldata_out <= '0;
                    pending    <= '0;
                end else begin
                    pldata_out <= mem[rd_ptr][2*PDATA_WIDTH-1:PDATA_WIDTH];
                    pending    <= mem[rd_ptr][PDATA_WIDTH-1:0];
                end
            end
            if (right_evt) begin
                prdata_out <= pending;
            end
        end
    end

endmodule
